// File: rtl/clock_extender.sv
// rtl/clock_extender.sv - programmable-duty stretched clock derived from clk
//
// Purpose: holds ExtendedClk low for LOW_CYCLES clk cycles, then high for
// HIGH_CYCLES clk cycles, repeating. Every output comes straight from a flop.
//
// Ports:
//   clk          in   1      system clock, rising-edge active
//   rst_n        in   1      asynchronous active-low reset
//   ExtendedClk  out  1      stretched clock, period LOW_CYCLES+HIGH_CYCLES
//   rise_pulse   out  1      one-cycle strobe in the cycle ExtendedClk becomes 1
//   fall_pulse   out  1      one-cycle strobe in the cycle ExtendedClk becomes 0
//   phase_cnt    out  CNT_W  clk cycles already spent in the current level
module clock_extender #(
    parameter int LOW_CYCLES  = 2,
    parameter int HIGH_CYCLES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             ExtendedClk,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] phase_cnt
);

    // Refuse to elaborate with a zero-length phase or a counter too narrow
    // to reach the terminal count of either phase.
    if (LOW_CYCLES < 1 || HIGH_CYCLES < 1) begin : g_bad_cycles
        $error("clock_extender: LOW_CYCLES and HIGH_CYCLES must be >= 1");
    end
    if ((LOW_CYCLES - 1) >= (2 ** CNT_W) || (HIGH_CYCLES - 1) >= (2 ** CNT_W)) begin : g_bad_width
        $error("clock_extender: CNT_W too narrow for LOW_CYCLES/HIGH_CYCLES");
    end

    localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic {
        ST_LOW  = 1'b0,
        ST_HIGH = 1'b1
    } state_t;

    state_t state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_LOW;
            phase_cnt   <= '0;
            ExtendedClk <= 1'b0;
            rise_pulse  <= 1'b0;
            fall_pulse  <= 1'b0;
        end else begin
            case (state)
                ST_LOW: begin
                    if (phase_cnt == LOW_LAST) begin
                        state       <= ST_HIGH;
                        phase_cnt   <= '0;
                        ExtendedClk <= 1'b1;
                        rise_pulse  <= 1'b1;
                        fall_pulse  <= 1'b0;
                    end else begin
                        phase_cnt   <= phase_cnt + CNT_ONE;
                        rise_pulse  <= 1'b0;
                        fall_pulse  <= 1'b0;
                    end
                end
                ST_HIGH: begin
                    if (phase_cnt == HIGH_LAST) begin
                        state       <= ST_LOW;
                        phase_cnt   <= '0;
                        ExtendedClk <= 1'b0;
                        rise_pulse  <= 1'b0;
                        fall_pulse  <= 1'b1;
                    end else begin
                        phase_cnt   <= phase_cnt + CNT_ONE;
                        rise_pulse  <= 1'b0;
                        fall_pulse  <= 1'b0;
                    end
                end
                default: begin
                    state       <= ST_LOW;
                    phase_cnt   <= '0;
                    ExtendedClk <= 1'b0;
                    rise_pulse  <= 1'b0;
                    fall_pulse  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_extender.sv
// tb/tb_clock_extender.sv - directed self-checking bench for clock_extender
module tb_clock_extender;

    logic       clk;
    logic       rst_n;

    logic       ext22, rise22, fall22;
    logic [7:0] cnt22;
    logic       ext11, rise11, fall11;
    logic [7:0] cnt11;
    logic       ext31, rise31, fall31;
    logic [7:0] cnt31;

    int checks   = 0;
    int failures = 0;

    clock_extender dut22 (
        .clk(clk), .rst_n(rst_n), .ExtendedClk(ext22),
        .rise_pulse(rise22), .fall_pulse(fall22), .phase_cnt(cnt22)
    );

    clock_extender #(.LOW_CYCLES(1), .HIGH_CYCLES(1), .CNT_W(8)) dut11 (
        .clk(clk), .rst_n(rst_n), .ExtendedClk(ext11),
        .rise_pulse(rise11), .fall_pulse(fall11), .phase_cnt(cnt11)
    );

    clock_extender #(.LOW_CYCLES(3), .HIGH_CYCLES(1), .CNT_W(8)) dut31 (
        .clk(clk), .rst_n(rst_n), .ExtendedClk(ext31),
        .rise_pulse(rise31), .fall_pulse(fall31), .phase_cnt(cnt31)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Hand-derived per-edge values for edges 1..8 after reset release.
    int e22_ext[8]  = '{0, 1, 1, 0, 0, 1, 1, 0};
    int e22_rise[8] = '{0, 1, 0, 0, 0, 1, 0, 0};
    int e22_fall[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    int e22_cnt[8]  = '{1, 0, 1, 0, 1, 0, 1, 0};

    int e11_ext[8]  = '{1, 0, 1, 0, 1, 0, 1, 0};
    int e11_rise[8] = '{1, 0, 1, 0, 1, 0, 1, 0};
    int e11_fall[8] = '{0, 1, 0, 1, 0, 1, 0, 1};

    int e31_ext[8]  = '{0, 0, 1, 0, 0, 0, 1, 0};
    int e31_rise[8] = '{0, 0, 1, 0, 0, 0, 1, 0};
    int e31_fall[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    int e31_cnt[8]  = '{1, 2, 0, 0, 1, 2, 0, 0};

    initial begin
        int r22, f22, r11, f11, r31, f31, both, edge_err;
        logic p22, p11, p31;

        // Reset held for 5 clk.
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst22_ext",  ext22,  0);
        check("rst22_rise", rise22, 0);
        check("rst22_fall", fall22, 0);
        check("rst22_cnt",  cnt22,  0);
        check("rst11_ext",  ext11,  0);
        check("rst11_cnt",  cnt11,  0);
        check("rst31_ext",  ext31,  0);
        check("rst31_cnt",  cnt31,  0);

        // Release off-edge; each following negedge samples one posedge result.
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("d22_ext_e%0d",  k + 1), ext22,  e22_ext[k]);
            check($sformatf("d22_rise_e%0d", k + 1), rise22, e22_rise[k]);
            check($sformatf("d22_fall_e%0d", k + 1), fall22, e22_fall[k]);
            check($sformatf("d22_cnt_e%0d",  k + 1), cnt22,  e22_cnt[k]);
            check($sformatf("d11_ext_e%0d",  k + 1), ext11,  e11_ext[k]);
            check($sformatf("d11_rise_e%0d", k + 1), rise11, e11_rise[k]);
            check($sformatf("d11_fall_e%0d", k + 1), fall11, e11_fall[k]);
            check($sformatf("d11_cnt_e%0d",  k + 1), cnt11,  0);
            check($sformatf("d31_ext_e%0d",  k + 1), ext31,  e31_ext[k]);
            check($sformatf("d31_rise_e%0d", k + 1), rise31, e31_rise[k]);
            check($sformatf("d31_fall_e%0d", k + 1), fall31, e31_fall[k]);
            check($sformatf("d31_cnt_e%0d",  k + 1), cnt31,  e31_cnt[k]);
        end

        // Edges 9 and 10 put the default instance back into its high phase.
        @(negedge clk);
        @(negedge clk);
        check("mid_pre_ext22", ext22, 1);
        check("mid_pre_rise22", rise22, 1);

        // Asynchronous reset in the middle of the high phase.
        @(posedge clk);
        #5 rst_n = 1'b0;
        #1;
        check("mid_async_ext22",  ext22,  0);
        check("mid_async_rise22", rise22, 0);
        check("mid_async_cnt22",  cnt22,  0);
        repeat (2) @(negedge clk);
        check("mid_hold_ext22", ext22, 0);
        check("mid_hold_ext11", ext11, 0);
        check("mid_hold_cnt22", cnt22, 0);

        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rel_e1_ext22", ext22, 0);
        check("mid_rel_e1_cnt22", cnt22, 1);
        @(negedge clk);
        check("mid_rel_e2_ext22",  ext22,  1);
        check("mid_rel_e2_rise22", rise22, 1);
        check("mid_rel_e2_ext31",  ext31,  0);
        check("mid_rel_e2_cnt31",  cnt31,  2);

        // Long run: strobe counts, exclusivity, strobes tied to level changes.
        r22 = 0; f22 = 0; r11 = 0; f11 = 0; r31 = 0; f31 = 0;
        both = 0; edge_err = 0;
        p22 = ext22; p11 = ext11; p31 = ext31;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            r22 += int'(rise22); f22 += int'(fall22);
            r11 += int'(rise11); f11 += int'(fall11);
            r31 += int'(rise31); f31 += int'(fall31);
            if ((rise22 && fall22) || (rise11 && fall11) || (rise31 && fall31))
                both++;
            if (rise22 !== (ext22 && !p22) || fall22 !== (!ext22 && p22)) edge_err++;
            if (rise11 !== (ext11 && !p11) || fall11 !== (!ext11 && p11)) edge_err++;
            if (rise31 !== (ext31 && !p31) || fall31 !== (!ext31 && p31)) edge_err++;
            p22 = ext22; p11 = ext11; p31 = ext31;
        end
        check_range("long_rise22", r22, 249, 251);
        check_range("long_fall22", f22, 249, 251);
        check_range("long_rise11", r11, 499, 501);
        check_range("long_fall11", f11, 499, 501);
        check_range("long_rise31", r31, 249, 251);
        check_range("long_fall31", f31, 249, 251);
        check("long_both_strobes", both, 0);
        check("long_strobe_vs_edge", edge_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
